// File: rtl/pe_dual.sv
// Dual-mode systolic processing element: output-stationary MAC or weight-stationary
// partial-sum pass-through, with a drain shift chain for unloading tile results.
module pe_dual #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SATURATE   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic                          clear_acc,
    input  logic signed [DATA_WIDTH-1:0]  a_in,
    input  logic                          a_vld_in,
    output logic signed [DATA_WIDTH-1:0]  a_out,
    output logic                          a_vld_out,
    input  logic signed [DATA_WIDTH-1:0]  b_in,
    input  logic                          b_vld_in,
    output logic signed [DATA_WIDTH-1:0]  b_out,
    output logic                          b_vld_out,
    input  logic                          w_load,
    input  logic signed [ACC_WIDTH-1:0]   psum_in,
    output logic signed [ACC_WIDTH-1:0]   psum_out,
    output logic                          psum_vld_out,
    input  logic                          drain_load,
    input  logic                          drain_shift,
    input  logic signed [ACC_WIDTH-1:0]   drain_in,
    output logic signed [ACC_WIDTH-1:0]   drain_out,
    output logic signed [ACC_WIDTH-1:0]   acc_out,
    output logic                          sat
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] w_q, w_d;
    logic signed [ACC_WIDTH-1:0]  acc_d, psum_d, drain_d;
    logic                         sat_d, psum_vld_d;
    logic signed [PW-1:0]         a_ext, b_ext, w_ext, prod_os, prod_ws;
    logic                         ovf_os, ovf_ws;

    assign a_ext   = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in};
    assign b_ext   = {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
    assign w_ext   = {{DATA_WIDTH{w_q[DATA_WIDTH-1]}}, w_q};
    assign prod_os = a_ext * b_ext;
    assign prod_ws = a_ext * w_ext;

    // One guard bit is enough: the two top bits of the widened sum disagree on overflow.
    function automatic logic signed [ACC_WIDTH-1:0] add_clip(
        input  logic signed [ACC_WIDTH-1:0] x,
        input  logic signed [PW-1:0]        p,
        output logic                        ovf
    );
        logic signed [ACC_WIDTH:0] xe, pe, s;
        xe  = {x[ACC_WIDTH-1], x};
        pe  = {{(ACC_WIDTH + 1 - PW){p[PW-1]}}, p};
        s   = xe + pe;
        ovf = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
        if (ovf && SATURATE != 0)
            add_clip = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            add_clip = s[ACC_WIDTH-1:0];
    endfunction

    always_comb begin
        acc_d      = acc_out;
        sat_d      = sat;
        psum_d     = psum_out;
        psum_vld_d = 1'b0;
        w_d        = w_q;
        drain_d    = drain_out;
        ovf_os     = 1'b0;
        ovf_ws     = 1'b0;

        if (clear_acc) begin
            acc_d = '0;
            sat_d = 1'b0;
        end

        if (!mode) begin
            // clear_acc with a MAC starts a new tile from this product alone
            if (a_vld_in && b_vld_in) begin
                acc_d = add_clip(clear_acc ? '0 : acc_out, prod_os, ovf_os);
                sat_d = sat_d | ovf_os;
            end
        end else begin
            if (w_load && b_vld_in)
                w_d = b_in;
            if (a_vld_in) begin
                psum_d     = add_clip(psum_in, prod_ws, ovf_ws);
                psum_vld_d = 1'b1;
                sat_d      = sat_d | ovf_ws;
            end
        end

        if (drain_load)
            drain_d = acc_out;
        else if (drain_shift)
            drain_d = drain_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out        <= '0;
            a_vld_out    <= 1'b0;
            b_out        <= '0;
            b_vld_out    <= 1'b0;
            w_q          <= '0;
            psum_out     <= '0;
            psum_vld_out <= 1'b0;
            drain_out    <= '0;
            acc_out      <= '0;
            sat          <= 1'b0;
        end else begin
            a_out        <= a_in;
            a_vld_out    <= a_vld_in;
            b_out        <= b_in;
            b_vld_out    <= b_vld_in;
            w_q          <= w_d;
            psum_out     <= psum_d;
            psum_vld_out <= psum_vld_d;
            drain_out    <= drain_d;
            acc_out      <= acc_d;
            sat          <= sat_d;
        end
    end

endmodule
